alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_addsub.sv | 19 +
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and datapath defaults for the sequential ALU.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_SLE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_addsub.sv
// Shared adder/subtractor: sum = a + b, or a + ~b + 1 when sub is set.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = sub ? ~b : b;
  assign w_full = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
  assign {cout, sum} = w_full;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU: single-cycle arithmetic/logic, 1-bit-per-cycle shifts,
// registered result and flags for the downstream set-result stage.
//
// state | meaning
// IDLE  | waiting for start; non-shift ops and zero-length shifts finish here
// SHIFT | acc shifted one bit per cycle, cnt counts down to 1
// DONE  | done pulse, busy still high, start ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             lessThan,
  output logic             lessEqual,
  output logic             busy,
  output logic             done
);

  alu_state_t         r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout, r_zero, r_lt, r_le;

  logic [WIDTH-1:0]   w_sum, w_res, w_acc_nxt;
  logic               w_add_cout, w_sub, w_cout, w_lt, w_le, w_is_shift;
  logic [SHAMT_W-1:0] w_k;

  assign w_sub = (op != ALU_ADD);
  assign w_k   = b[SHAMT_W-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_add_cout)
  );

  // Shifts with a non-zero amount go to SHIFT; here they just pass a through.
  always_comb begin
    w_res      = '0;
    w_cout     = 1'b0;
    w_lt       = 1'b0;
    w_le       = 1'b0;
    w_is_shift = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin w_res = w_sum; w_cout = w_add_cout; end
      ALU_SLT: begin w_res = w_sum; w_cout = w_add_cout; w_lt = 1'b1; end
      ALU_SLE: begin w_res = w_sum; w_cout = w_add_cout; w_le = 1'b1; end
      ALU_AND: w_res = a & b;
      ALU_OR:  w_res = a | b;
      ALU_XOR: w_res = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: begin w_res = a; w_is_shift = 1'b1; end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    case (r_op)
      ALU_SLL: w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0};
      ALU_SRL: w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
      default: w_acc_nxt = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_le     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= op;
            if (w_is_shift && (w_k != '0)) begin
              r_acc   <= a;
              r_cnt   <= w_k;
              r_state <= ST_SHIFT;
            end else begin
              r_result <= w_res;
              r_cout   <= w_cout;
              r_zero   <= (w_res == '0);
              r_lt     <= w_lt;
              r_le     <= w_le;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result <= w_acc_nxt;
            r_cout   <= 1'b0;
            r_zero   <= (w_acc_nxt == '0);
            r_lt     <= 1'b0;
            r_le     <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign lessThan  = r_lt;
  assign lessEqual = r_le;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued at start and
// compared when done rises, together with latency and busy/hold behaviour.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
  logic         cout, zero, lessThan, lessEqual, busy, done;

  alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .lessThan  (lessThan),
    .lessEqual (lessEqual),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c, z, lt, le;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] t;
    int          k;
    k     = int'(y[4:0]);
    e.c   = 1'b0;
    e.lt  = 1'b0;
    e.le  = 1'b0;
    e.lat = 1;
    e.res = '0;
    case (o)
      ALU_ADD: begin t = {1'b0, x} + {1'b0, y}; e.res = t[31:0]; e.c = t[32]; end
      ALU_SUB, ALU_SLT, ALU_SLE: begin
        t = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.res = t[31:0];
        e.c   = t[32];
        e.lt  = (o == ALU_SLT);
        e.le  = (o == ALU_SLE);
      end
      ALU_AND: e.res = x & y;
      ALU_OR:  e.res = x | y;
      ALU_XOR: e.res = x ^ y;
      ALU_SLL: begin e.res = x << k; e.lat = k + 1; end
      ALU_SRL: begin e.res = x >> k; e.lat = k + 1; end
      ALU_SRA: begin e.res = $unsigned($signed(x) >>> k); e.lat = k + 1; end
      default: e.res = '0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // poke_at > 0 pulses start (an ADD) on that wait cycle; it must be ignored.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int poke_at);
    exp_t e;
    int   cyc;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 64) begin
      chk("busy_wait", 64'(busy), 64'd1);
      chk("hold_result", 64'(result), 64'(last_res));
      if (cyc == poke_at) begin
        start = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("result", 64'(result), 64'(e.res));
    chk("cout", 64'(cout), 64'(e.c));
    chk("zero", 64'(zero), 64'(e.z));
    chk("lessThan", 64'(lessThan), 64'(e.lt));
    chk("lessEqual", 64'(lessEqual), 64'(e.le));
    chk("busy_done", 64'(busy), 64'd1);
    last_res = e.res;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("hold_after", 64'(result), 64'(last_res));
  endtask

  initial begin
    logic        seen;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({cout, zero, lessThan, lessEqual, busy, done}), 64'd0);
    rst = 1'b0;

    do_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_SLT, 32'd3, 32'd5, 0);
    do_op(ALU_SLE, 32'd5, 32'd5, 0);
    do_op(ALU_SUB, 32'd5, 32'd7, 0);
    do_op(ALU_SRA, 32'h8000_0000, 32'd31, 5);
    do_op(ALU_SLL, 32'h1234_5678, 32'd0, 0);
    do_op(ALU_SRL, 32'h0000_0010, 32'd4, 0);
    do_op(ALU_OR,  32'hA5A5_0000, 32'h0000_5A5A, 0);
    do_op(ALU_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    do_op(4'd12,   32'h1234_5678, 32'h1111_1111, 0);
    do_op(ALU_SLL, 32'h0000_0003, 32'hFFFF_FFE3, 0);
    do_op(ALU_SRL, 32'h8000_0000, 32'd1, 0);

    // Reset during a long shift aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = ALU_SLL; a = 32'd1; b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      seen |= done;
      @(negedge clk);
    end
    seen |= done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'({cout, zero, lessThan, lessEqual, busy, done}), 64'd0);
    last_res = '0;

    do_op(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 0);

    for (int i = 0; i < 20; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (ro == ALU_SLL || ro == ALU_SRL || ro == ALU_SRA)
        rb = (rb & 32'hFFFF_FFE0) | 32'($urandom_range(0, 6));
      else if ((i % 5) == 0)
        rb = ra;
      do_op(ro, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
